// File: rtl/pudding_thermo_loader.sv
// Converts a binary DAC code into a 128-cell thermometer pattern (optionally DWA-rotated),
// shifts it into the DAC daisy chain and commits it with a single transfer pulse.
module pudding_thermo_loader #(
    parameter int N_CELLS = 128,
    parameter int CODE_W  = 8,
    parameter int PTR_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              dwa_en,
    input  logic              ptr_clr,
    output logic              datum,
    output logic              shift,
    output logic              transfer,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic [PTR_W-1:0]  ptr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [PTR_W-1:0]  TOP_CELL = PTR_W'(N_CELLS - 1);
    localparam logic [CODE_W-1:0] SAT_MAX  = CODE_W'(N_CELLS);

    state_t              state, state_n;
    logic [PTR_W-1:0]    cnt, cnt_n;
    logic [CODE_W-1:0]   code_sat, code_sat_n;
    logic [PTR_W-1:0]    base, base_n;
    logic                dwa_lat, dwa_lat_n;
    logic [PTR_W-1:0]    ptr_n;
    logic                datum_n, shift_n, transfer_n, dir_n, busy_n, done_n, ready_n;
    logic [CODE_W-1:0]   acc_sat;
    logic [PTR_W-1:0]    acc_base;
    logic [PTR_W-1:0]    cnt_inc;

    // Cell j is lit when its distance above the rotation base (mod N_CELLS) is below the code.
    function automatic logic pattern_bit(input logic [PTR_W-1:0] j,
                                         input logic [PTR_W-1:0] b,
                                         input logic [CODE_W-1:0] sat);
        logic [PTR_W-1:0] diff;
        diff = j - b;
        return CODE_W'(diff) < sat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            code_sat   <= '0;
            base       <= '0;
            dwa_lat    <= 1'b0;
            ptr        <= '0;
            datum      <= 1'b0;
            shift      <= 1'b0;
            transfer   <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            code_ready <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            code_sat   <= code_sat_n;
            base       <= base_n;
            dwa_lat    <= dwa_lat_n;
            ptr        <= ptr_n;
            datum      <= datum_n;
            shift      <= shift_n;
            transfer   <= transfer_n;
            dir        <= dir_n;
            busy       <= busy_n;
            done       <= done_n;
            code_ready <= ready_n;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        code_sat_n = code_sat;
        base_n     = base;
        dwa_lat_n  = dwa_lat;
        ptr_n      = ptr;
        datum_n    = 1'b0;
        shift_n    = 1'b0;
        transfer_n = 1'b0;
        dir_n      = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        ready_n    = 1'b0;
        acc_sat    = (code > SAT_MAX) ? SAT_MAX : code;
        acc_base   = (dwa_en && !ptr_clr) ? ptr : '0;
        cnt_inc    = cnt + PTR_W'(1);

        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
                if (ptr_clr) begin
                    ptr_n = '0;
                end
                if (code_valid) begin
                    state_n    = S_SHIFT;
                    code_sat_n = acc_sat;
                    base_n     = acc_base;
                    dwa_lat_n  = dwa_en;
                    cnt_n      = '0;
                    shift_n    = 1'b1;
                    busy_n     = 1'b1;
                    ready_n    = 1'b0;
                    datum_n    = pattern_bit(TOP_CELL, acc_base, acc_sat);
                end
            end
            S_SHIFT: begin
                busy_n = 1'b1;
                if (cnt == TOP_CELL) begin
                    state_n    = S_XFER;
                    transfer_n = 1'b1;
                    dir_n      = 1'b1;
                end else begin
                    cnt_n   = cnt_inc;
                    shift_n = 1'b1;
                    datum_n = pattern_bit(TOP_CELL - cnt_inc, base, code_sat);
                end
            end
            S_XFER: begin
                if (dwa_lat) begin
                    ptr_n = ptr + PTR_W'(code_sat);
                end
                state_n = S_DONE;
                done_n  = 1'b1;
                ready_n = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pudding_thermo_loader.sv
// Self-checking bench for pudding_thermo_loader: models the DAC chain/state and checks
// every load against a thermometer/DWA reference computed with plain integer arithmetic.
module tb_pudding_thermo_loader;

    localparam int N = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   code = '0;
    logic         code_valid = 1'b0;
    logic         dwa_en = 1'b0;
    logic         ptr_clr = 1'b0;
    logic         code_ready, datum, shift, transfer, dir, busy, done;
    logic [6:0]   ptr;

    int           total = 0;
    int           bad = 0;
    int           model_ptr = 0;
    logic [127:0] exp_pat;
    logic [127:0] chain;
    logic [127:0] dac;

    pudding_thermo_loader #(.N_CELLS(128), .CODE_W(8), .PTR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
        .code_ready(code_ready), .dwa_en(dwa_en), .ptr_clr(ptr_clr),
        .datum(datum), .shift(shift), .transfer(transfer), .dir(dir),
        .busy(busy), .done(done), .ptr(ptr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_pattern(input int b, input int sat);
        logic [127:0] p;
        for (int j = 0; j < N; j++) begin
            p[j] = ((((j - b) % N) + N) % N) < sat;
        end
        return p;
    endfunction

    // Drive a request at the current negedge and advance the reference model.
    task automatic apply_stimulus(input int c, input bit d, input bit clr);
        int sat;
        int b;
        check_output("ready_at_present", {127'b0, code_ready}, 128'd1);
        sat = (c > N) ? N : c;
        b   = (d && !clr) ? model_ptr : 0;
        if (clr) model_ptr = 0;
        exp_pat = exp_pattern(b, sat);
        if (d) model_ptr = (model_ptr + sat) % N;
        code       = c[7:0];
        dwa_en     = d;
        ptr_clr    = clr;
        code_valid = 1'b1;
    endtask

    // Follow one load cycle by cycle; abort_at > 0 returns early at that cycle's negedge.
    task automatic track(input int abort_at);
        int   first_sh, nsh, xfer_c, done_c, derr, viol;
        logic ready_at_done;
        first_sh = -1; nsh = 0; xfer_c = -1; done_c = -1; derr = 0; viol = 0;
        ready_at_done = 1'b0;
        chain = '0;
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        ptr_clr    = 1'b0;
        code       = 8'($urandom);
        dwa_en     = 1'($urandom);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (abort_at > 0 && cyc == abort_at) return;
            if (shift) begin
                if (first_sh < 0) first_sh = cyc;
                if (cyc > N || datum !== exp_pat[N - cyc]) derr++;
                chain = {chain[126:0], datum};
                nsh++;
            end
            if (shift && transfer) viol++;
            if (dir !== transfer) viol++;
            if (busy !== (shift || transfer)) viol++;
            if (transfer && dir) begin
                xfer_c = cyc;
                dac    = chain;
            end
            if (done) begin
                done_c        = cyc;
                ready_at_done = code_ready;
                break;
            end
            @(negedge clk);
        end
        check_output("done_cycle", 128'(done_c), 128'd130);
        check_output("first_shift", 128'(first_sh), 128'd1);
        check_output("shift_count", 128'(nsh), 128'd128);
        check_output("xfer_cycle", 128'(xfer_c), 128'd129);
        check_output("datum_errs", 128'(derr), 128'd0);
        check_output("strobe_rules", 128'(viol), 128'd0);
        check_output("dac_state", dac, exp_pat);
        check_output("ptr_after", {121'b0, ptr}, 128'(model_ptr));
        check_output("ready_at_done", {127'b0, ready_at_done}, 128'd1);
    endtask

    initial begin
        int xfer_seen;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_output("rst_ready", {127'b0, code_ready}, 128'd1);
        check_output("rst_strobes", {124'b0, shift, transfer, done, dir}, 128'd0);
        check_output("rst_busy", {127'b0, busy}, 128'd0);
        check_output("rst_ptr", {121'b0, ptr}, 128'd0);

        apply_stimulus(5, 1'b0, 1'b0);
        track(0);
        check_output("code5_state", dac, 128'h1F);
        check_output("code5_ptr", {121'b0, ptr}, 128'd0);

        repeat (2) @(negedge clk);
        apply_stimulus(100, 1'b1, 1'b0);
        track(0);
        check_output("dwa100_state", dac, {28'h0, {100{1'b1}}});
        apply_stimulus(50, 1'b1, 1'b0);
        track(0);
        check_output("dwa50_state", dac, {{28{1'b1}}, 78'b0, {22{1'b1}}});
        check_output("dwa50_ptr", {121'b0, ptr}, 128'd22);

        apply_stimulus(200, 1'b1, 1'b0);
        track(0);
        check_output("sat_state", dac, {128{1'b1}});
        check_output("sat_ptr", {121'b0, ptr}, 128'd22);
        apply_stimulus(0, 1'b1, 1'b0);
        track(0);
        check_output("zero_state", dac, 128'd0);
        check_output("zero_ptr", {121'b0, ptr}, 128'd22);

        apply_stimulus(98, 1'b1, 1'b0);
        track(0);
        check_output("ptr120", {121'b0, ptr}, 128'd120);
        apply_stimulus(16, 1'b1, 1'b1);
        track(0);
        check_output("clr_state", dac, 128'hFFFF);
        check_output("clr_ptr", {121'b0, ptr}, 128'd16);

        repeat (3) @(negedge clk);
        apply_stimulus(70, 1'b1, 1'b0);
        track(60);
        rst_n = 1'b0;
        #1;
        check_output("midrst_outs", {122'b0, datum, shift, transfer, dir, busy, done}, 128'd0);
        check_output("midrst_ptr", {121'b0, ptr}, 128'd0);
        xfer_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (transfer) xfer_seen++;
        end
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        if (transfer) xfer_seen++;
        check_output("midrst_no_xfer", 128'(xfer_seen), 128'd0);
        check_output("midrst_ready", {127'b0, code_ready}, 128'd1);
        check_output("midrst_ptr_rel", {121'b0, ptr}, 128'd0);
        apply_stimulus(33, 1'b1, 1'b0);
        track(0);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            apply_stimulus(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0));
            track(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
